// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU with valid/ready handshakes.
// Single-cycle integer ops retire in one cycle; MUL/MULHU/DIV/DIVU/REM/REMU
// iterate one bit per cycle over a shared 2*XLEN accumulator.
module alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg,
  output logic            carry,
  output logic            overflow,
  output logic            busy
);

  localparam int unsigned AW  = 2 * XLEN;
  localparam int unsigned CW  = $clog2(XLEN);
  localparam int unsigned MSB = XLEN - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [AW-1:0]   acc, acc_nxt;
  logic [XLEN-1:0] a_q, b_q, a_nxt, b_nxt;
  logic [3:0]      op_q, op_nxt;
  logic            out_valid_nxt;
  logic [XLEN-1:0] result_nxt;
  logic            zero_nxt, neg_nxt, carry_nxt, overflow_nxt;

  logic            accept;

  logic [XLEN:0]   sum;
  logic            is_addsub, is_mul, is_div, div_signed, div_special;
  logic [XLEN-1:0] imm_res, a_mag;
  logic            imm_carry, imm_ovf;

  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic [XLEN-1:0] dvs, quot, remd, fin_res;
  logic            q_neg, r_neg;
  logic [AW-1:0]   step;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy     = (state == CALC);
  assign accept   = in_valid && in_ready;

  // Single-cycle result, flags and divide special cases from the request operands
  always_comb begin
    is_addsub   = (op[3:1] == 3'b000);
    is_mul      = (op[3:1] == 3'b100);
    is_div      = (op[3:2] == 2'b11);
    div_signed  = is_div && !op[0];
    sum         = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + (XLEN+1)'(op[0]);
    a_mag       = (div_signed && a[MSB]) ? (-a) : a;
    div_special = is_div && ((b == '0) ||
                  (div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
    imm_res     = '0;
    case (op)
      OP_ADD, OP_SUB: imm_res = sum[XLEN-1:0];
      OP_AND:         imm_res = a & b;
      OP_OR:          imm_res = a | b;
      OP_XOR:         imm_res = a ^ b;
      OP_SLT:         imm_res = XLEN'($signed(a) < $signed(b));
      OP_SLTU:        imm_res = XLEN'(a < b);
      default:        imm_res = '0;
    endcase
    if (div_special) begin
      if (b == '0) imm_res = op[1] ? a : '1;
      else         imm_res = op[1] ? '0 : a;
    end
    imm_carry = is_addsub && sum[XLEN];
    imm_ovf   = is_addsub && (a[MSB] == (b[MSB] ^ op[0])) && (sum[MSB] != a[MSB]);
  end

  // One shift-add or restoring-divide step plus final sign fix-up
  always_comb begin
    dvs     = (!op_q[0] && b_q[MSB]) ? (-b_q) : b_q;
    mul_sum = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
    rem_sh  = {acc[AW-1:XLEN], acc[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs};
    if (op_q[2]) begin
      step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                        : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc[XLEN-1:1]};
    end
    quot  = step[XLEN-1:0];
    remd  = step[AW-1:XLEN];
    q_neg = !op_q[0] && (a_q[MSB] ^ b_q[MSB]);
    r_neg = !op_q[0] && a_q[MSB];
    if (!op_q[2])     fin_res = op_q[0] ? remd : quot;
    else if (op_q[1]) fin_res = r_neg ? (-remd) : remd;
    else              fin_res = q_neg ? (-quot) : quot;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    a_nxt         = a_q;
    b_nxt         = b_q;
    op_nxt        = op_q;
    out_valid_nxt = out_valid;
    result_nxt    = result;
    zero_nxt      = zero;
    neg_nxt       = neg;
    carry_nxt     = carry;
    overflow_nxt  = overflow;
    case (state)
      IDLE: ;
      CALC: begin
        acc_nxt = step;
        if (cnt == '0) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
          result_nxt    = fin_res;
          zero_nxt      = (fin_res == '0);
          neg_nxt       = fin_res[MSB];
          carry_nxt     = 1'b0;
          overflow_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      a_nxt  = a;
      b_nxt  = b;
      op_nxt = op;
      if ((is_mul || is_div) && !div_special) begin
        state_nxt     = CALC;
        cnt_nxt       = CW'(XLEN - 1);
        out_valid_nxt = 1'b0;
        acc_nxt       = {{XLEN{1'b0}}, (is_div ? a_mag : b)};
      end else begin
        state_nxt     = DONE;
        out_valid_nxt = 1'b1;
        result_nxt    = imm_res;
        zero_nxt      = (imm_res == '0);
        neg_nxt       = imm_res[MSB];
        carry_nxt     = imm_carry;
        overflow_nxt  = imm_ovf;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      op_q      <= op_nxt;
      out_valid <= out_valid_nxt;
      result    <= result_nxt;
      zero      <= zero_nxt;
      neg       <= neg_nxt;
      carry     <= carry_nxt;
      overflow  <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned XLEN = 32;
  localparam int LONG_LAT = XLEN + 1;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero, neg, carry, overflow, busy;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .carry(carry),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z, n, c, v;
    int          lat;
    int          busy_cyc;
    int          acc_cyc;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          busy_cnt = 0;
  bit          held = 0;
  logic [35:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    exp_t e;
    longint          sx, sy, s, q;
    longint unsigned ux, uy, r, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    e.res = 32'd0; e.c = 1'b0; e.v = 1'b0;
    e.lat = 1; e.busy_cyc = 0; e.acc_cyc = 0; e.op = o;
    case (o)
      4'b0000: begin
        r = ux + uy; e.res = r[31:0]; e.c = r[32];
        s = sx + sy; e.v = (s > SMAX) || (s < SMIN);
      end
      4'b0001: begin
        r = ux - uy; e.res = r[31:0]; e.c = (ux >= uy);
        s = sx - sy; e.v = (s > SMAX) || (s < SMIN);
      end
      4'b0010: e.res = x & y;
      4'b0011: e.res = x | y;
      4'b0100: e.res = x ^ y;
      4'b0101: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'b0110: e.res = (ux < uy) ? 32'd1 : 32'd0;
      4'b1000, 4'b1001: begin
        p = ux * uy;
        e.res = o[0] ? p[63:32] : p[31:0];
        e.lat = LONG_LAT; e.busy_cyc = XLEN;
      end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        if (y == 32'd0) begin
          e.res = o[1] ? x : 32'hFFFF_FFFF;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.res = o[1] ? 32'd0 : x;
        end else begin
          e.lat = LONG_LAT; e.busy_cyc = XLEN;
          if (!o[0]) q = o[1] ? (sx % sy) : (sx / sy);
          else       q = longint'(o[1] ? (ux % uy) : (ux / uy));
          e.res = q[31:0];
        end
      end
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Hold a request until accepted, then log the expected response
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic [3:0] top);
    exp_t e;
    int   guard;
    e = model(ta, tb_v, top);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    guard = 0;
    #2;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #2;
      guard++;
    end
    if (guard >= 200) begin
      errors++; checks++;
      $display("FAIL accept_timeout: op=%0h never accepted", top);
    end else begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'($urandom); b = 32'($urandom); op = 4'($urandom);
  endtask

  // Monitor: drives out_ready, pops and compares on each output handshake
  initial begin
    exp_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
      #2;
      if (rst) begin
        busy_cnt = 0;
        held = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          chk("in_ready_during_calc", in_ready, 0);
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL stray_out_valid: actual out_valid=1 result=0x%0h required out_valid=0", result);
          end else begin
            e = sb[0];
            if (held) begin
              chk("stable_under_backpressure", {result, zero, neg, carry, overflow}, snap);
            end else begin
              chk($sformatf("latency[op%0h]", e.op), cyc - e.acc_cyc, e.lat);
              chk($sformatf("busy_cycles[op%0h]", e.op), busy_cnt, e.busy_cyc);
              busy_cnt = 0;
            end
            if (out_ready) begin
              chk($sformatf("result[op%0h]", e.op), result, e.res);
              chk($sformatf("flags_zncv[op%0h]", e.op), {zero, neg, carry, overflow},
                  {e.z, e.n, e.c, e.v});
              void'(sb.pop_front());
              held = 0;
            end else begin
              chk("in_ready_while_stalled", in_ready, 0);
              snap = {result, zero, neg, carry, overflow};
              held = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {zero, neg, carry, overflow}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases: back-to-back issue with out_ready held high
    issue(32'h7FFF_FFFF, 32'd1, 4'b0000);
    issue(32'd5, 32'd5, 4'b0001);
    issue(32'hFFFF_FFFF, 32'd1, 4'b0101);
    issue(32'hFFFF_FFFF, 32'd1, 4'b0110);
    issue(32'hFFFF_FFFF, 32'd2, 4'b1000);
    issue(32'hFFFF_FFFF, 32'd2, 4'b1001);
    issue(32'hFFFF_FFF9, 32'd2, 4'b1100);
    issue(32'hFFFF_FFF9, 32'd2, 4'b1110);
    issue(32'd100, 32'd7, 4'b1101);
    issue(32'd100, 32'd7, 4'b1111);
    issue(32'd123, 32'd0, 4'b1101);
    issue(32'd123, 32'd0, 4'b1110);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b1100);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 4'b1110);
    issue(32'hDEAD_BEEF, 32'h1234_5678, 4'b0111);
    issue(32'hDEAD_BEEF, 32'h1234_5678, 4'b1010);
    issue(32'h8000_0000, 32'h8000_0000, 4'b0001);

    // Backpressure: hold out_ready low for five cycles
    issue(32'd1, 32'd2, 4'b0000);
    rdy_mode = 2;
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a DIV
    issue(32'h1234_5678, 32'd7, 4'b1100);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midcalc_reset_out_valid", out_valid, 0);
    chk("midcalc_reset_result", result, 0);
    chk("midcalc_reset_flags", {zero, neg, carry, overflow}, 0);
    chk("midcalc_reset_busy", busy, 0);
    chk("midcalc_reset_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);

    // Randomized traffic with random backpressure and gaps
    rdy_mode = 1;
    repeat (200) begin
      if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      issue(rnd_val(), rnd_val(), 4'($urandom_range(15)));
    end

    rdy_mode = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    #4;
    chk("drain_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
